apb_rr_master: RTL

Multi-requester APB master that shares one APB port between NUM_REQ on-chip requesters. Requests are arbitrated round-robin, and each grant is driven as a protocol-correct IDLE/SETUP/ACCESS transfer. Each transfer completes with a per-requester response pulse carrying read data and error status. The block sits between the SoC-side command sources and the peripheral APB bus, and replaces the fixed single-command APB sequencer.

---
 rtl/apb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/apb_rr_master.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase encoding and default bus widths.
package apb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a pointer that
// moves past the winner on each advance strobe.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx;
  logic          found;

  // First requester at or above ptr, wrapping modulo N
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PW'((32'(ptr) + off) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (32'(gnt_idx) == N - 1) ? '0 : PW'(32'(gnt_idx) + 1);
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Shares one APB master port among NUM_REQ requesters with round-robin
// arbitration, wait-state handling, timeout and per-requester responses.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ-1:0]          req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic [ADDR_W-1:0]           paddr_o,
  output logic                        pwrite_o,
  output logic [DATA_W-1:0]           pwdata_o,
  input  logic                        pready_i,
  input  logic [DATA_W-1:0]           prdata_i,
  input  logic                        pslverr_i
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  apb_state_t           state, state_n;
  logic [TW-1:0]        tcnt;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   cap_gnt;
  logic                 arb_point;
  logic                 complete;
  logic                 advance;
  logic                 sel_write;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid_i),
    .advance (advance),
    .gnt     (gnt)
  );

  // Next-state logic; arbitration happens in IDLE and on the completing ACCESS cycle
  always_comb begin
    state_n   = state;
    arb_point = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        arb_point = 1'b1;
        state_n   = (|req_valid_i) ? ST_SETUP : ST_IDLE;
      end
      ST_SETUP: begin
        state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        complete = pready_i || (tcnt == TW'(TIMEOUT));
        if (complete) begin
          arb_point = 1'b1;
          state_n   = (|req_valid_i) ? ST_SETUP : ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign advance     = arb_point && (|req_valid_i);
  assign req_ready_o = advance ? gnt : '0;

  // Winner's request fields
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_write = req_write_i[i];
        sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
    end else begin
      state     <= state_n;
      psel_o    <= (state_n != ST_IDLE);
      penable_o <= (state_n == ST_ACCESS);
    end
  end

  // ACCESS-cycle counter: 1 on entry, cleared outside ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state_n == ST_ACCESS) begin
      tcnt <= (state == ST_ACCESS) ? TW'(tcnt + 1'b1) : TW'(1);
    end else begin
      tcnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_gnt  <= '0;
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
    end else if (advance) begin
      cap_gnt  <= gnt;
      pwrite_o <= sel_write;
      paddr_o  <= sel_addr;
      pwdata_o <= sel_wdata;
    end
  end

  // Response lands the cycle after completion; data only for clean reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else if (complete) begin
      rsp_valid_o <= cap_gnt;
      rsp_err_o   <= pready_i ? pslverr_i : 1'b1;
      rsp_rdata_o <= (pready_i && !pslverr_i && !pwrite_o) ? prdata_i : '0;
    end else begin
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end
  end

endmodule
